rv32_wb_stage: RTL and testbench
================================

# rv32_wb_stage

Writeback stage of the RV32 pipeline and the consumer of the MEM/WB pipeline register outputs. Each cycle it selects the writeback source, sign- or zero-extends load data, drives the register-file write port, and publishes a one-cycle bypass copy of the last write for the decode stage. It also runs the halt drain state machine and the optional retired-instruction counter.

## Interface
- No parameters.
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- alu_res  in  32  ALU result; for loads, the effective byte address
- bshift  in  32  barrel-shifter result
- pc_ret  in  32  return address (PC+4)
- data_res  in  32  aligned 32-bit word read from data memory
- rf  in  3  [0] = write request; [2:1] = source: 00 alu_res, 01 bshift, 10 pc_ret, 11 load data
- pc_hlt  in  1  active-low halt marker; 0 = this instruction is HALT
- code  in  32  instruction word; 32'd0 = bubble
- sel_rd1  in  5  destination register index
- rf_we  out  1  register-file write enable
- rf_waddr  out  5  write address
- rf_wdata  out  32  write data
- byp_valid  out  1  bypass entry valid
- byp_rd  out  5  bypass register index
- byp_data  out  32  bypass data
- misalign  out  1  misaligned-load pulse
- halted  out  1  core halted
- instret  out  64  retired-instruction count

## Operation
- Valid instruction: code != 0 and FSM not HALTED.
- Load: code[6:0] == 7'b0000011. funct3 = code[14:12]; offset = alu_res[1:0].
- Load extract: LB/LBU (000/100) select byte offset, sign/zero-extend. LH/LHU (001/101) select half offset[1], sign/zero-extend. LW (010) passes the word.
- Misalign: assert on LH/LHU with offset[0] = 1, or LW with offset != 0. The write is suppressed. Other funct3 values on a load also suppress the write; misalign stays low.
- rf_we = valid & rf[0] & (sel_rd1 != 0) & ~misalign & state != HALTED.
- rf_waddr = sel_rd1. rf_wdata = the selected source.
- Halt FSM (states RUN, DRAIN, HALTED):
  - RUN → DRAIN when a valid instruction has pc_hlt = 0. The HALT instruction itself retires and may write.
  - DRAIN → HALTED unconditionally after one cycle. In DRAIN, writes and retirement proceed normally.
  - HALTED is sticky until reset. In HALTED: rf_we = 0, the bypass is not loaded, instret is frozen, and halted = 1.
- Bypass register: on each clock, byp_valid ← rf_we, byp_rd ← rf_waddr, byp_data ← rf_wdata.
- instret: increments by 1 for each valid instruction that is not misaligned. It is 64-bit and wraps from all-ones to 0.

## Timing
- rf_we, rf_waddr, rf_wdata and misalign are combinational from the inputs and the current state (0 latency).
- byp_valid, byp_rd, byp_data, halted and instret are registered (1-cycle latency).
- HALT presented in cycle N: FSM is DRAIN in N+1; halted = 1 from N+2.
- Reset values: byp_valid 0, byp_rd 0, byp_data 0, halted 0, instret 0, FSM RUN.
- Under reset the combinational outputs follow inputs. With the pipeline register's reset values (code = 0, rf = 0), rf_we = 0 and misalign = 0.
- Reset asserted mid-operation: all state clears immediately and asynchronously. A write in flight in that cycle is not captured into the bypass.
- HALT instruction that is misaligned: no write and no retire count, but the FSM still enters DRAIN.

## Configuration
- RV32_WB_INSTRET_EN defined: the 64-bit instret counter is built as described.
- Undefined: no counter register exists, and instret is tied to 64'd0.

## Structure
- Shared package rv32_pkg holds:
  - wb_src_e enum (ALU, BSHIFT, PCRET, LOAD)
  - wb_state_e enum (RUN, DRAIN, HALTED)
  - OPC_LOAD constant
  - funct3 constants F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU
- One sub-module, rv32_load_extend: combinational. Inputs funct3, offset, word; outputs data and misalign.

## Test plan
- Source select: rf = 3'b001, sel_rd1 = 5, alu_res = 0x1234 → rf_we = 1, waddr = 5, wdata = 0x1234; next cycle byp_valid = 1, byp_rd = 5, byp_data = 0x1234. Repeat with rf = 011 (bshift), 101 (pc_ret) and 111 (load data).
- Load extend: data_res = 0x80FF7F01, LB offset 3 → 0xFFFFFF80; LBU offset 3 → 0x00000080; LH offset 2 → 0xFFFF80FF; LHU offset 0 → 0x00007F01.
- Misalign: LW with alu_res = 0x1002, rf = 111 → misalign = 1, rf_we = 0, instret unchanged.
- x0 and bubble: sel_rd1 = 0 with rf = 001 → rf_we = 0 but instret +1; code = 0 → rf_we = 0 and instret unchanged.
- Halt: addi x3 with pc_hlt = 0 in cycle N → x3 written in N; a following write in N+1 succeeds; halted = 1 at N+2; a write presented at N+2 is blocked; instret stays frozen.
- Reset and config: assert rst_n low mid-stream → all registered outputs 0, FSM RUN. Build without RV32_WB_INSTRET_EN → instret = 0 throughout.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32 pipeline types and constants: writeback source select, halt FSM states,
// load opcode and load funct3 encodings.
package rv32_pkg;

  typedef enum logic [1:0] {
    ALU    = 2'b00,
    BSHIFT = 2'b01,
    PCRET  = 2'b10,
    LOAD   = 2'b11
  } wb_src_e;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DRAIN  = 2'b01,
    HALTED = 2'b10
  } wb_state_e;

  localparam logic [6:0] OPC_LOAD = 7'b0000011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/rv32_load_extend.sv
// Load data extraction: picks byte/half/word at the address offset and sign/zero-extends.
// Purely combinational (0 latency); no flow control.
module rv32_load_extend
  import rv32_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  output logic [31:0] data,
  output logic        misalign
);

  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign shifted  = word >> {offset, 3'b000};
  assign byte_sel = shifted[7:0];
  assign half_sel = offset[1] ? word[31:16] : word[15:0];

  always_comb begin
    data     = word;
    misalign = 1'b0;
    case (funct3)
      F3_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU: data = {24'd0, byte_sel};
      F3_LH: begin
        data     = {{16{half_sel[15]}}, half_sel};
        misalign = offset[0];
      end
      F3_LHU: begin
        data     = {16'd0, half_sel};
        misalign = offset[0];
      end
      F3_LW:  misalign = |offset;
      default: data = word;
    endcase
  end

endmodule

// File: rtl/rv32_wb_stage.sv
// RV32 writeback: source select, load extend, RF write port, bypass register, halt drain FSM.
// RF port/misalign 0-cycle, bypass/halted/instret 1-cycle; no backpressure. RV32_WB_INSTRET_EN builds instret.
module rv32_wb_stage
  import rv32_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] alu_res,
  input  logic [31:0] bshift,
  input  logic [31:0] pc_ret,
  input  logic [31:0] data_res,
  input  logic [2:0]  rf,
  input  logic        pc_hlt,
  input  logic [31:0] code,
  input  logic [4:0]  sel_rd1,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        byp_valid,
  output logic [4:0]  byp_rd,
  output logic [31:0] byp_data,
  output logic        misalign,
  output logic        halted,
  output logic [63:0] instret
);

  wb_state_e   state_q, state_d;
  logic        valid;
  logic        is_load;
  logic        ld_illegal;
  logic        ld_misalign;
  logic [2:0]  funct3;
  logic [31:0] ld_data;
  logic        retire;
  logic        byp_valid_q;
  logic [4:0]  byp_rd_q;
  logic [31:0] byp_data_q;

  assign funct3  = code[14:12];
  assign is_load = (code[6:0] == OPC_LOAD);
  assign valid   = (code != 32'd0) && (state_q != HALTED);

  rv32_load_extend u_load_extend (
    .funct3   (funct3),
    .offset   (alu_res[1:0]),
    .word     (data_res),
    .data     (ld_data),
    .misalign (ld_misalign)
  );

  // Reserved load funct3 encodings retire but never write.
  assign ld_illegal = is_load && !(funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
  assign misalign   = valid && is_load && ld_misalign;
  assign retire     = valid && !misalign;

  always_comb begin
    rf_wdata = alu_res;
    case (wb_src_e'(rf[2:1]))
      ALU:     rf_wdata = alu_res;
      BSHIFT:  rf_wdata = bshift;
      PCRET:   rf_wdata = pc_ret;
      LOAD:    rf_wdata = is_load ? ld_data : data_res;
      default: rf_wdata = alu_res;
    endcase
  end

  assign rf_we    = valid && rf[0] && (sel_rd1 != 5'd0) && !misalign && !ld_illegal;
  assign rf_waddr = sel_rd1;

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (valid && !pc_hlt) state_d = DRAIN;
      DRAIN:   state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      byp_valid_q <= 1'b0;
      byp_rd_q    <= 5'd0;
      byp_data_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      if (state_q != HALTED) begin
        byp_valid_q <= rf_we;
        byp_rd_q    <= rf_waddr;
        byp_data_q  <= rf_wdata;
      end
    end
  end

  assign byp_valid = byp_valid_q;
  assign byp_rd    = byp_rd_q;
  assign byp_data  = byp_data_q;
  assign halted    = (state_q == HALTED);

`ifdef RV32_WB_INSTRET_EN
  logic [63:0] instret_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_q <= 64'd0;
    end else if (retire) begin
      instret_q <= instret_q + 64'd1;
    end
  end

  assign instret = instret_q;
`else
  logic unused_retire;
  assign unused_retire = retire;
  assign instret       = 64'd0;
`endif

endmodule

// File: tb/tb_rv32_wb_stage.sv
// Directed bench for rv32_wb_stage: source select, load extend, misalign, x0/bubble,
// halt drain, async reset; instret expectation follows RV32_WB_INSTRET_EN.
module tb_rv32_wb_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] alu_res, bshift, pc_ret, data_res, code;
  logic [2:0]  rf;
  logic        pc_hlt;
  logic [4:0]  sel_rd1;
  logic        rf_we, byp_valid, misalign, halted;
  logic [4:0]  rf_waddr, byp_rd;
  logic [31:0] rf_wdata, byp_data;
  logic [63:0] instret;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_cnt = 64'd0;

  localparam logic [31:0] ADDI = 32'h0010_0293;

  rv32_wb_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_res   (alu_res),
    .bshift    (bshift),
    .pc_ret    (pc_ret),
    .data_res  (data_res),
    .rf        (rf),
    .pc_hlt    (pc_hlt),
    .code      (code),
    .sel_rd1   (sel_rd1),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .byp_valid (byp_valid),
    .byp_rd    (byp_rd),
    .byp_data  (byp_data),
    .misalign  (misalign),
    .halted    (halted),
    .instret   (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ld(input logic [2:0] f3);
    return {17'd0, f3, 5'd8, 7'b0000011};
  endfunction

  function automatic logic [63:0] exp_ir();
`ifdef RV32_WB_INSTRET_EN
    return exp_cnt;
`else
    return 64'd0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic [31:0] c, input logic [2:0] r, input logic [4:0] rd,
                       input logic [31:0] alu, input logic hlt);
    code    = c;
    rf      = r;
    sel_rd1 = rd;
    alu_res = alu;
    pc_hlt  = hlt;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic [4:0] rd, input logic [31:0] d);
    chk({tag, "_we"}, 64'(rf_we), 64'd1);
    chk({tag, "_waddr"}, 64'(rf_waddr), 64'(rd));
    chk({tag, "_wdata"}, 64'(rf_wdata), 64'(d));
    tick();
    exp_cnt++;
    chk({tag, "_byp_valid"}, 64'(byp_valid), 64'd1);
    chk({tag, "_byp_rd"}, 64'(byp_rd), 64'(rd));
    chk({tag, "_byp_data"}, 64'(byp_data), 64'(d));
    chk({tag, "_instret"}, instret, exp_ir());
  endtask

  initial begin
    rst_n = 1'b0; code = 32'd0; rf = 3'd0; sel_rd1 = 5'd0; pc_hlt = 1'b1;
    alu_res = 32'd0; bshift = 32'hB5B5_0000; pc_ret = 32'h0000_2004; data_res = 32'h80FF_7F01;
    #12;
    chk("rst_byp_valid", 64'(byp_valid), 64'd0);
    chk("rst_byp_data", 64'(byp_data), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_instret", instret, 64'd0);
    chk("rst_we", 64'(rf_we), 64'd0);
    chk("rst_misalign", 64'(misalign), 64'd0);
    rst_n = 1'b1;
    tick();

    // Source select
    drive(ADDI, 3'b001, 5'd5, 32'h1234, 1'b1);   chk_wr("src_alu", 5'd5, 32'h1234);
    drive(ADDI, 3'b011, 5'd6, 32'h1234, 1'b1);   chk_wr("src_bsh", 5'd6, 32'hB5B5_0000);
    drive(ADDI, 3'b101, 5'd7, 32'h1234, 1'b1);   chk_wr("src_pc", 5'd7, 32'h0000_2004);
    drive(ld(3'b010), 3'b111, 5'd8, 32'h1000, 1'b1); chk_wr("src_lw", 5'd8, 32'h80FF_7F01);

    // Load extend
    drive(ld(3'b000), 3'b111, 5'd9, 32'h1003, 1'b1); chk_wr("lb3", 5'd9, 32'hFFFF_FF80);
    drive(ld(3'b100), 3'b111, 5'd9, 32'h1003, 1'b1); chk_wr("lbu3", 5'd9, 32'h0000_0080);
    drive(ld(3'b001), 3'b111, 5'd9, 32'h1002, 1'b1); chk_wr("lh2", 5'd9, 32'hFFFF_80FF);
    drive(ld(3'b101), 3'b111, 5'd9, 32'h1000, 1'b1); chk_wr("lhu0", 5'd9, 32'h0000_7F01);

    // Misaligned LW: no write, no retire
    drive(ld(3'b010), 3'b111, 5'd9, 32'h1002, 1'b1);
    chk("mis_misalign", 64'(misalign), 64'd1);
    chk("mis_we", 64'(rf_we), 64'd0);
    tick();
    chk("mis_byp_valid", 64'(byp_valid), 64'd0);
    chk("mis_instret", instret, exp_ir());

    // x0 destination retires without writing
    drive(ADDI, 3'b001, 5'd0, 32'h55, 1'b1);
    chk("x0_we", 64'(rf_we), 64'd0);
    tick(); exp_cnt++;
    chk("x0_instret", instret, exp_ir());

    // Bubble neither writes nor retires
    drive(32'd0, 3'b001, 5'd9, 32'h55, 1'b1);
    chk("bub_we", 64'(rf_we), 64'd0);
    tick();
    chk("bub_instret", instret, exp_ir());

    // Reserved load funct3: no write, no misalign, retires
    drive(ld(3'b011), 3'b111, 5'd9, 32'h1000, 1'b1);
    chk("f3bad_we", 64'(rf_we), 64'd0);
    chk("f3bad_misalign", 64'(misalign), 64'd0);
    tick(); exp_cnt++;
    chk("f3bad_instret", instret, exp_ir());

    // Halt drain
    drive(ADDI, 3'b001, 5'd3, 32'h33, 1'b0);
    chk("hN_we", 64'(rf_we), 64'd1);
    tick(); exp_cnt++;
    chk("hN_halted", 64'(halted), 64'd0);
    chk("hN_byp_rd", 64'(byp_rd), 64'd3);
    drive(ADDI, 3'b001, 5'd4, 32'h44, 1'b1);
    chk("hN1_we", 64'(rf_we), 64'd1);
    tick(); exp_cnt++;
    chk("hN2_halted", 64'(halted), 64'd1);
    chk("hN2_byp_data", 64'(byp_data), 64'h44);
    chk("hN2_instret", instret, exp_ir());
    drive(ADDI, 3'b001, 5'd10, 32'hAA, 1'b1);
    chk("hN2_we", 64'(rf_we), 64'd0);
    tick();
    chk("hN3_halted", 64'(halted), 64'd1);
    chk("hN3_byp_valid", 64'(byp_valid), 64'd1);
    chk("hN3_byp_rd", 64'(byp_rd), 64'd4);
    chk("hN3_instret", instret, exp_ir());

    // Asynchronous reset mid-cycle while a write is presented
    drive(ADDI, 3'b001, 5'd11, 32'hBB, 1'b1);
    rst_n = 1'b0;
    #1;
    exp_cnt = 64'd0;
    chk("arst_halted", 64'(halted), 64'd0);
    chk("arst_byp_rd", 64'(byp_rd), 64'd0);
    chk("arst_byp_data", 64'(byp_data), 64'd0);
    chk("arst_instret", instret, 64'd0);
    tick();
    chk("arst_hold_byp_valid", 64'(byp_valid), 64'd0);
    rst_n = 1'b1;
    drive(ADDI, 3'b001, 5'd12, 32'hCC, 1'b1);    chk_wr("post_rst", 5'd12, 32'hCC);

    // Misaligned HALT: no write/retire, still drains to HALTED
    drive(ld(3'b001), 3'b111, 5'd13, 32'h1001, 1'b0);
    chk("mhalt_misalign", 64'(misalign), 64'd1);
    chk("mhalt_we", 64'(rf_we), 64'd0);
    tick();
    chk("mhalt_instret", instret, exp_ir());
    chk("mhalt_drain_halted", 64'(halted), 64'd0);
    drive(32'd0, 3'b000, 5'd0, 32'd0, 1'b1);
    tick();
    chk("mhalt_halted", 64'(halted), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
